// File: rtl/sha256_digest_serializer.sv
// Captures one SHA-256 digest and streams it MSB-byte-first to a UART transmitter, one strobe per tx_done.
// Define SHA256_SER_HEX_ASCII_EN to send lowercase ASCII hex characters followed by CR LF instead of raw bytes.
module sha256_digest_serializer #(
    parameter int DIGEST_BYTES = 32,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*DIGEST_BYTES-1:0] digest_in,
    input  logic                      digest_valid,
    output logic                      ready,
    output logic                      tx_dv,
    output logic [7:0]                tx_byte,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      done,
    output logic                      drop
);
    // state  | meaning
    // IDLE   | waiting for a digest, ready=1
    // SEND   | tx_dv strobe cycle for the current character
    // WAIT   | waiting for tx_done of the current character
    // GAP    | idle spacing before the next strobe
    // FINISH | done pulse, then back to IDLE
    localparam int SREG_W = 8 * DIGEST_BYTES;
    localparam int IDX_W  = $clog2(2 * DIGEST_BYTES + 2);
    localparam int GAP_W  = 8;
`ifdef SHA256_SER_HEX_ASCII_EN
    localparam int STEP = 4;
    localparam int LAST = 2 * DIGEST_BYTES + 1;
`else
    localparam int STEP = 8;
    localparam int LAST = DIGEST_BYTES - 1;
`endif

    typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, FINISH} state_t;

    state_t             state;
    logic [SREG_W-1:0]  sreg;
    logic [SREG_W-1:0]  sreg_shifted;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         char_first;
    logic [7:0]         char_now;
    logic [7:0]         char_next;
    logic               rst_meta_n;
    logic               rst_sync_n;

    // Deassertion is taken through two flops; captures are held off until it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    assign sreg_shifted = sreg << STEP;
    assign idx_inc      = idx + IDX_W'(1);

`ifdef SHA256_SER_HEX_ASCII_EN
    function automatic logic [7:0] hex_char(input logic [IDX_W-1:0] k, input logic [3:0] nib);
        if (k == IDX_W'(2 * DIGEST_BYTES)) return 8'h0d;
        if (k == IDX_W'(LAST))             return 8'h0a;
        if (nib < 4'd10)                   return {4'h3, nib};
        return 8'h57 + {4'h0, nib};
    endfunction

    assign char_first = hex_char('0, digest_in[SREG_W-1 -: 4]);
    assign char_now   = hex_char(idx, sreg[SREG_W-1 -: 4]);
    assign char_next  = hex_char(idx_inc, sreg_shifted[SREG_W-1 -: 4]);
`else
    assign char_first = digest_in[SREG_W-1 -: 8];
    assign char_now   = sreg[SREG_W-1 -: 8];
    assign char_next  = sreg_shifted[SREG_W-1 -: 8];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
            done    <= 1'b0;
            drop    <= 1'b0;
            sreg    <= '0;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            tx_dv <= 1'b0;
            done  <= 1'b0;
            drop  <= digest_valid && !ready;
            case (state)
                IDLE: begin
                    if (digest_valid && rst_sync_n) begin
                        sreg    <= digest_in;
                        idx     <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        tx_dv   <= 1'b1;
                        tx_byte <= char_first;
                        state   <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        if (idx == IDX_W'(LAST)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end else begin
                            sreg <= sreg_shifted;
                            idx  <= idx_inc;
                            if (GAP_CYCLES > 0) begin
                                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                                state   <= GAP;
                            end else begin
                                tx_dv   <= 1'b1;
                                tx_byte <= char_next;
                                state   <= SEND;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= char_now;
                        state   <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                FINISH: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Bench for sha256_digest_serializer: two instances (no gap / 4-cycle gap) checked against a character-queue model.
// The expected stream follows SHA256_SER_HEX_ASCII_EN when the bundle is built with it.
module tb_sha256_digest_serializer;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] digest_in    [2];
    logic         digest_valid [2];
    logic         tx_done      [2];
    logic         ready        [2];
    logic         tx_dv        [2];
    logic [7:0]   tx_byte      [2];
    logic         busy         [2];
    logic         done         [2];
    logic         drop         [2];

    logic [7:0]   exp_q[$];
    int           vectors     = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    sha256_digest_serializer #(.DIGEST_BYTES(32), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .digest_in(digest_in[0]), .digest_valid(digest_valid[0]),
        .ready(ready[0]), .tx_dv(tx_dv[0]), .tx_byte(tx_byte[0]), .tx_done(tx_done[0]),
        .busy(busy[0]), .done(done[0]), .drop(drop[0])
    );

    sha256_digest_serializer #(.DIGEST_BYTES(32), .GAP_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .digest_in(digest_in[1]), .digest_valid(digest_valid[1]),
        .ready(ready[1]), .tx_dv(tx_dv[1]), .tx_byte(tx_byte[1]), .tx_done(tx_done[1]),
        .busy(busy[1]), .done(done[1]), .drop(drop[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // The transmitted stream as text/bytes, independent of how the DUT walks through it.
    task automatic build_expected(input logic [255:0] d);
`ifdef SHA256_SER_HEX_ASCII_EN
        string s;
        s = $sformatf("%064h", d);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0d);
        exp_q.push_back(8'h0a);
`else
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(d[255 - 8*i -: 8]);
`endif
    endtask

    function automatic logic [255:0] rand_digest();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic check_idle(input int u, input string tag);
        check_eq({tag, "_tx_dv"}, tx_dv[u], 1'b0);
        check_eq({tag, "_busy"},  busy[u],  1'b0);
        check_eq({tag, "_ready"}, ready[u], 1'b1);
    endtask

    task automatic idle_done_pulses(input int u);
        for (int i = 0; i < 3; i++) begin
            tx_done[u] = 1'b1;
            @(negedge clk);
            tx_done[u] = 1'b0;
            check_idle(u, "idle_txdone");
            @(negedge clk);
        end
    endtask

    // One digest, cycle by cycle. delay 0 = random turnaround; abort_at >= 0 resets mid-stream.
    task automatic run_digest(input int u, input logic [255:0] d, input int fixed_delay,
                              input int drop_at, input int abort_at,
                              input bit done_on_capture, input bit finish_drop);
        int n;
        int delay;
        int gap;
        gap = (u == 1) ? 4 : 0;
        build_expected(d);
        n = exp_q.size();
        @(negedge clk);
        check_eq("ready_before", ready[u], 1'b1);
        digest_in[u]    = d;
        digest_valid[u] = 1'b1;
        tx_done[u]      = done_on_capture;
        @(negedge clk);
        digest_valid[u] = 1'b0;
        tx_done[u]      = 1'b0;
        check_eq("busy_start",  busy[u],  1'b1);
        check_eq("ready_start", ready[u], 1'b0);
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("tx_dv_%0d", k),   tx_dv[u],   1'b1);
            check_eq($sformatf("tx_byte_%0d", k), tx_byte[u], exp_q[k]);
            tx_done[u] = ($urandom_range(0, 3) == 0);
            delay = (fixed_delay > 0) ? fixed_delay : $urandom_range(3, 12);
            if ((k == drop_at || k == abort_at) && delay < 5) delay = 5;
            for (int w = 1; w < delay; w++) begin
                @(negedge clk);
                tx_done[u] = 1'b0;
                check_eq($sformatf("wait_tx_dv_%0d", k),   tx_dv[u],   1'b0);
                check_eq($sformatf("hold_tx_byte_%0d", k), tx_byte[u], exp_q[k]);
                if (k == drop_at && w == 1) begin
                    digest_in[u]    = ~d;
                    digest_valid[u] = 1'b1;
                end
                if (k == drop_at && w == 2) begin
                    digest_valid[u] = 1'b0;
                    check_eq("drop_pulse", drop[u], 1'b1);
                end
                if (k == drop_at && w == 3) check_eq("drop_clear", drop[u], 1'b0);
                if (k == abort_at && w == 3) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle(u, "abort");
                    check_eq("abort_done", done[u], 1'b0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (3) @(negedge clk);
                    tx_done[u] = 1'b1;
                    @(negedge clk);
                    tx_done[u] = 1'b0;
                    check_idle(u, "late_txdone");
                    return;
                end
            end
            @(negedge clk);
            tx_done[u] = 1'b1;
            @(negedge clk);
            tx_done[u] = 1'b0;
            if (k == n - 1) begin
                check_eq("done_pulse",   done[u],  1'b1);
                check_eq("finish_busy",  busy[u],  1'b0);
                check_eq("finish_ready", ready[u], 1'b0);
                if (finish_drop) begin
                    digest_in[u]    = ~d;
                    digest_valid[u] = 1'b1;
                end
                @(negedge clk);
                digest_valid[u] = 1'b0;
                check_eq("done_clear",  done[u],  1'b0);
                check_eq("ready_after", ready[u], 1'b1);
                check_eq("after_tx_dv", tx_dv[u], 1'b0);
                check_eq("finish_drop", drop[u],  finish_drop);
                if (finish_drop) begin
                    @(negedge clk);
                    check_idle(u, "post_drop");
                end
            end else begin
                for (int g = 0; g < gap; g++) begin
                    check_eq($sformatf("gap_tx_dv_%0d", k), tx_dv[u], 1'b0);
                    tx_done[u] = (g == 1);
                    @(negedge clk);
                end
                tx_done[u] = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            digest_in[u]    = '0;
            digest_valid[u] = 1'b0;
            tx_done[u]      = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_idle(u, "reset");
            check_eq("reset_tx_byte", tx_byte[u], 8'h00);
            check_eq("reset_done",    done[u],    1'b0);
            check_eq("reset_drop",    drop[u],    1'b0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_digest(0, ABC_DIGEST, 20, -1, -1, 1'b0, 1'b0);
        run_digest(0, rand_digest(), 0, 5, -1, 1'b0, 1'b1);
        idle_done_pulses(0);
        run_digest(0, rand_digest(), 0, -1, -1, 1'b1, 1'b0);
        run_digest(0, rand_digest(), 0, -1, 10, 1'b0, 1'b0);
        run_digest(0, ABC_DIGEST, 0, -1, -1, 1'b0, 1'b0);
        run_digest(1, ABC_DIGEST, 0, -1, -1, 1'b0, 1'b0);
        idle_done_pulses(1);
        run_digest(1, rand_digest(), 0, 7, -1, 1'b1, 1'b1);
        for (int r = 0; r < 4; r++)
            run_digest(r % 2, rand_digest(), 0, -1, -1, 1'b0, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
